// File: rtl/i2c_req_arbiter_if.sv
// Requester and I2C_Top command bundle for i2c_req_arbiter.
// master: the arbiter; slave: requesters plus the I2C_Top master.
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 7,
    parameter int ADDRESS_WIDTH = 6
);
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0]                   req_rw_bar;
    logic [NUM_REQ*(ADDRESS_WIDTH+1)-1:0] req_addr;
    logic [NUM_REQ*(DATA_WIDTH+1)-1:0]    req_wdata;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_REQ-1:0]                   rsp_valid;
    logic [DATA_WIDTH:0]                  rsp_rdata;
    logic                                 rsp_err;
    logic                                 m_new_data;
    logic                                 m_rw_bar;
    logic [ADDRESS_WIDTH:0]               m_addr;
    logic [DATA_WIDTH:0]                  m_wdata;
    logic [DATA_WIDTH:0]                  m_rdata;
    logic                                 m_done;

    modport master (
        input  req_valid, req_rw_bar, req_addr, req_wdata,
        input  m_rdata, m_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output m_new_data, m_rw_bar, m_addr, m_wdata
    );

    modport slave (
        output req_valid, req_rw_bar, req_addr, req_wdata,
        output m_rdata, m_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  m_new_data, m_rw_bar, m_addr, m_wdata
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C_Top master between NUM_REQ clients.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP, all outputs registered.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 7,
    parameter int ADDRESS_WIDTH  = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    i2c_req_arbiter_if.master     bus,
    output logic                  busy
);
    localparam int DW = DATA_WIDTH + 1;
    localparam int AW = ADDRESS_WIDTH + 1;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       grant_q, grant_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                m_new_data_q, m_new_data_d;
    logic                m_rw_bar_q, m_rw_bar_d;
    logic [AW-1:0]       m_addr_q, m_addr_d;
    logic [DW-1:0]       m_wdata_q, m_wdata_d;
    logic                busy_q, busy_d;

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       cand_idx;
    int                  cand;

    // Search upward from the pointer, wrapping, for the first pending request.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!pick_found && bus.req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state, latched command and registered-output values.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        tmo_d      = tmo_q;
        m_rw_bar_d = m_rw_bar_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = ISSUE;
                    grant_d    = pick_idx;
                    m_rw_bar_d = bus.req_rw_bar[pick_idx];
                    m_addr_d   = bus.req_addr[int'(pick_idx)*AW +: AW];
                    m_wdata_d  = bus.req_wdata[int'(pick_idx)*DW +: DW];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tmo_d   = '0;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.m_done) begin
                    state_d     = RESP;
                    rsp_rdata_d = m_rw_bar_q ? bus.m_rdata : '0;
                    rsp_err_d   = 1'b0;
                    m_rw_bar_d  = 1'b0;
                    m_addr_d    = '0;
                    m_wdata_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = RESP;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    m_rw_bar_d  = 1'b0;
                    m_addr_d    = '0;
                    m_wdata_d   = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (int'(grant_q) == NUM_REQ - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == ISSUE) ? (ONE << grant_d) : '0;
        m_new_data_d = (state_d == ISSUE);
        rsp_valid_d  = (state_d == RESP) ? (ONE << grant_d) : '0;
        busy_d       = (state_d != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, grant, timer and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q        <= '0;
            grant_q      <= '0;
            tmo_q        <= '0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            m_new_data_q <= 1'b0;
            m_rw_bar_q   <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            tmo_q        <= tmo_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            m_new_data_q <= m_new_data_d;
            m_rw_bar_q   <= m_rw_bar_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.m_new_data = m_new_data_q;
    assign bus.m_rw_bar   = m_rw_bar_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: stimulus pushes expected
// commands/responses, a negedge monitor pops and compares them.
module tb_i2c_req_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 16;

    typedef struct packed {
        logic [1:0] idx;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;

    cmd_t       cmd_q[$];
    rsp_t       rsp_q[$];
    cmd_t       mc_got, mc_exp;
    rsp_t       mr_got, mr_exp;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         nd_cnt = 0;
    int         rsp_cnt = 0;
    int         issue_cyc = 0;
    int         last_lat = 0;
    int         tgt[NR] = '{default: 0};
    int         seen[NR] = '{default: 0};

    int         model_lat = 0;
    logic [7:0] model_rdata = 8'h00;
    logic       mdl_done = 1'b0;
    logic [7:0] mdl_rdata = 8'h00;
    logic       idle_done = 1'b0;

    i2c_req_arbiter_if #(
        .NUM_REQ(NR), .DATA_WIDTH(7), .ADDRESS_WIDTH(6)
    ) bus ();

    i2c_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(7), .ADDRESS_WIDTH(6),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // A requester stays valid until it has been granted as often as posted.
    always_comb begin
        bus.req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = (seen[i] < tgt[i]);
        end
    end

    assign bus.m_done  = mdl_done | idle_done;
    assign bus.m_rdata = mdl_rdata;

    function automatic logic [1:0] oh2idx(input logic [NR-1:0] v);
        oh2idx = '0;
        for (int i = 0; i < NR; i++) begin
            if (v[i]) oh2idx = 2'(i);
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // I2C_Top model: done after model_lat WAIT cycles; 0 means never.
    initial forever begin
        @(negedge clk);
        if (!reset && bus.m_new_data && model_lat != 0) begin
            repeat (model_lat) @(negedge clk);
            mdl_done  = 1'b1;
            mdl_rdata = model_rdata;
            @(negedge clk);
            mdl_done  = 1'b0;
            mdl_rdata = 8'h00;
        end
    end

    // Monitor: compare every command issue and every response.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.m_new_data || (|bus.req_ready)) begin
                if (bus.m_new_data) nd_cnt++;
                issue_cyc = cyc;
                check("ready_onehot", 32'($onehot(bus.req_ready)), 32'd1);
                check("new_data_with_ready", 32'(bus.m_new_data), 32'd1);
                mc_got = {oh2idx(bus.req_ready), bus.m_rw_bar,
                          bus.m_addr, bus.m_wdata};
                if (|bus.req_ready) seen[mc_got.idx]++;
                if (cmd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cmd_unexpected: got %0h want none", mc_got);
                end else begin
                    mc_exp = cmd_q.pop_front();
                    check("cmd", 32'(mc_got), 32'(mc_exp));
                end
            end
            if (|bus.rsp_valid) begin
                rsp_cnt++;
                last_lat = cyc - issue_cyc;
                check("rsp_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
                mr_got = {oh2idx(bus.rsp_valid), bus.rsp_rdata, bus.rsp_err};
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got %0h want none", mr_got);
                end else begin
                    mr_exp = rsp_q.pop_front();
                    check("rsp", 32'(mr_got), 32'(mr_exp));
                end
            end else begin
                check("rsp_idle_zero", 32'({bus.rsp_rdata, bus.rsp_err}), 32'd0);
            end
        end
    end

    task automatic post(input int i, input logic rw,
                        input logic [6:0] a, input logic [7:0] d);
        bus.req_rw_bar[i]       = rw;
        bus.req_addr[i*7 +: 7]  = a;
        bus.req_wdata[i*8 +: 8] = d;
        tgt[i]++;
    endtask

    task automatic exp_cmd(input int i, input logic rw,
                           input logic [6:0] a, input logic [7:0] d);
        cmd_q.push_back({2'(i), rw, a, d});
    endtask

    task automatic exp_rsp(input int i, input logic [7:0] rd, input logic e);
        rsp_q.push_back({2'(i), rd, e});
    endtask

    task automatic wait_rsp(input int n);
        int b;
        b = 0;
        while (rsp_cnt < n && b < 400) begin
            @(negedge clk);
            b++;
        end
        @(negedge clk);
        if (rsp_cnt < n) begin
            total++;
            bad++;
            $display("FAIL wait_rsp: got %0d want %0d", rsp_cnt, n);
        end
    endtask

    task automatic wait_ready(input int i);
        int b;
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!bus.req_ready[i] && b < 100);
        if (!bus.req_ready[i]) begin
            total++;
            bad++;
            $display("FAIL wait_ready%0d: got 0 want 1", i);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.req_rw_bar = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_new_data", 32'(bus.m_new_data), 32'd0);
        check("rst_cmd_bus", 32'({bus.m_rw_bar, bus.m_addr, bus.m_wdata}), 32'd0);
        check("rst_rsp_bus", 32'({bus.rsp_rdata, bus.rsp_err}), 32'd0);
        reset = 1'b0;

        // single write; read data from the model must be discarded
        model_lat   = 10;
        model_rdata = 8'hEE;
        exp_cmd(0, 1'b0, 7'h2A, 8'hA5);
        exp_rsp(0, 8'h00, 1'b0);
        post(0, 1'b0, 7'h2A, 8'hA5);
        wait_rsp(1);
        check("write_latency", 32'(last_lat), 32'd11);

        // single read
        model_lat   = 3;
        model_rdata = 8'h3C;
        exp_cmd(1, 1'b1, 7'h51, 8'h00);
        exp_rsp(1, 8'h3C, 1'b0);
        post(1, 1'b1, 7'h51, 8'h00);
        wait_rsp(2);
        check("read_latency", 32'(last_lat), 32'd4);

        // contention 0101 from pointer 0
        pulse_reset();
        model_lat   = 2;
        model_rdata = 8'h77;
        begin
            int nd0;
            nd0 = nd_cnt;
            exp_cmd(0, 1'b0, 7'h10, 8'h11);
            exp_cmd(2, 1'b0, 7'h12, 8'h13);
            exp_rsp(0, 8'h00, 1'b0);
            exp_rsp(2, 8'h00, 1'b0);
            post(0, 1'b0, 7'h10, 8'h11);
            post(2, 1'b0, 7'h12, 8'h13);
            wait_rsp(4);
            repeat (10) @(negedge clk);
            check("contention_new_data", 32'(nd_cnt - nd0), 32'd2);
        end

        // fairness: all four hold requests for two transactions each
        pulse_reset();
        model_lat   = 2;
        model_rdata = 8'h5A;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                exp_cmd(i, 1'b1, 7'(7'h20 + i), 8'h00);
                exp_rsp(i, 8'h5A, 1'b0);
            end
        end
        for (int i = 0; i < NR; i++) begin
            post(i, 1'b1, 7'(7'h20 + i), 8'h00);
            tgt[i]++;
        end
        wait_rsp(12);

        // timeout with no done
        model_lat = 0;
        exp_cmd(0, 1'b0, 7'h33, 8'h44);
        exp_rsp(0, 8'h00, 1'b1);
        post(0, 1'b0, 7'h33, 8'h44);
        wait_rsp(13);
        check("timeout_latency", 32'(last_lat), 32'd17);

        // done while idle must not start anything
        idle_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_done_busy", 32'(busy), 32'd0);
            check("idle_done_new_data", 32'(bus.m_new_data), 32'd0);
        end
        idle_done = 1'b0;

        // reset five cycles into WAIT
        exp_cmd(1, 1'b1, 7'h55, 8'h00);
        post(1, 1'b1, 7'h55, 8'h00);
        wait_ready(1);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_new_data", 32'(bus.m_new_data), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_addr", 32'(bus.m_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        model_lat   = 2;
        model_rdata = 8'h99;
        exp_cmd(3, 1'b1, 7'h66, 8'h00);
        exp_rsp(3, 8'h99, 1'b0);
        post(3, 1'b1, 7'h66, 8'h00);
        wait_rsp(14);

        repeat (5) @(negedge clk);
        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("rsp_total", 32'(rsp_cnt), 32'd14);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
